i2c_target: RTL and testbench

Synchronous I2C target (responder) that answers the write and read transactions issued by the team's I2C initiator. It oversamples SCL/SDA on the system clock, matches a 7-bit device address and exposes a 16 × 8-bit register file. Every byte write is also reported as a one-cycle strobe to local logic. It is the bench and loopback counterpart of the initiator and also serves as a local config endpoint on the shared bus.

---
 rtl/i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : Oversampled I2C target with 7-bit address match and a 2^PTR_W x 8
//            register file; byte writes are also reported as a one-cycle strobe.
// Revision : 1.0
// ============================================================================
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] local_addr,
    output logic [7:0]       local_rdata,
    output logic             busy
);

    localparam int c_DEPTH = 1 << PTR_W;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         scl_q, sda_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               rw_q, rw_d;
    logic               ack_q, ack_d;
    logic               wr_en_q, wr_en_d;
    logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic [7:0]         regs_q [c_DEPTH];

    logic               w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]         w_byte;

    // Stage 2 is the synchronized level; stage 3 is its previous value.
    assign w_scl_rise = scl_q[1] & ~scl_q[2];
    assign w_scl_fall = ~scl_q[1] & scl_q[2];
    assign w_start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign w_stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign w_byte     = {shift_q[6:0], sda_q[1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (w_stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (w_start) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise && cnt_q < 4'd8) begin
                        shift_d = w_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                rw_d = w_byte[0];
                                if (w_byte[7:1] != DEV_ADDR) begin
                                    state_d = ST_IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == ST_WDATA) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = w_byte;
                                ptr_d     = ptr_q + 1'b1;
                            end
                        end
                    end else if (w_scl_fall && cnt_q == 4'd8) begin
                        oe_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else if (state_q == ST_PTR) begin
                            state_d = ST_PTR_ACK;
                            ptr_d   = shift_q[PTR_W-1:0];
                        end else begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d = ST_RDATA;
                            shift_d = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                        end else begin
                            state_d = ST_PTR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        state_d = ST_WDATA;
                        cnt_d   = 4'd0;
                        oe_d    = 1'b0;
                    end
                end
                ST_RDATA: begin
                    // Bit 7 is already on the bus at entry; each fall advances one bit.
                    if (w_scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            state_d = ST_RDATA_ACK;
                            oe_d    = 1'b0;
                            ptr_d   = ptr_q + 1'b1;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        ack_d = ~sda_q[1];
                    end else if (w_scl_fall) begin
                        if (ack_q) begin
                            state_d = ST_RDATA;
                            cnt_d   = 4'd0;
                            shift_d = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                        end else begin
                            state_d = ST_IGNORE;
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            scl_q     <= {scl_q[1:0], scl_in};
            sda_q     <= {sda_q[1:0], sda_in};
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (wr_en_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign sda_oe      = oe_q;
    assign busy        = busy_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign local_rdata = regs_q[local_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Directed bench for i2c_target using a bit-banged I2C initiator.
// Revision : 1.0
// ============================================================================
module tb_i2c_target;

    localparam int c_Q = 8;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m;
    logic        sda_oe, wr_en, busy;
    logic [3:0]  wr_addr, local_addr;
    logic [7:0]  wr_data, local_rdata;
    wire         sda_line = sda_m & ~sda_oe;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          oe_seen, busy_seen;
    logic        mon_en = 1'b0;
    logic [11:0] wr_log [$];

    i2c_target #(.DEV_ADDR(7'h39), .PTR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .local_addr  (local_addr),
        .local_rdata (local_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (mon_en) begin
            if (sda_oe) oe_seen++;
            if (busy)   busy_seen++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wq();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        local_addr = a;
        @(negedge clk);
        check_eq(tag, local_rdata, exp);
    endtask

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] v;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; local_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) check_reg("rst_reg", 4'(i), 8'h00);

        // Burst write: ptr 3, A5 then 5A
        i2c_start();
        write_byte(8'h72, a); check_eq("bw_ack_addr", a, 1);
        write_byte(8'h03, a); check_eq("bw_ack_ptr", a, 1);
        write_byte(8'hA5, a); check_eq("bw_ack_d0", a, 1);
        write_byte(8'h5A, a); check_eq("bw_ack_d1", a, 1);
        check_eq("bw_busy", busy, 1);
        i2c_stop(); wq();
        check_eq("bw_busy_after", busy, 0);
        check_eq("bw_wr_cnt", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check_eq("bw_wr0", wr_log[0], 12'h3A5);
            check_eq("bw_wr1", wr_log[1], 12'h45A);
        end
        check_reg("bw_reg3", 4'd3, 8'hA5);
        check_reg("bw_reg4", 4'd4, 8'h5A);

        // Combined read with repeated start
        wr_log.delete();
        i2c_start();
        write_byte(8'h72, a); check_eq("cr_ack_addr", a, 1);
        write_byte(8'h03, a); check_eq("cr_ack_ptr", a, 1);
        i2c_start();
        write_byte(8'h73, a); check_eq("cr_ack_raddr", a, 1);
        read_byte(d, 1'b1); check_eq("cr_rd0", d, 8'hA5);
        read_byte(d, 1'b0); check_eq("cr_rd1", d, 8'h5A);
        check_eq("cr_oe_nack", sda_oe, 0);
        i2c_stop(); wq();
        check_eq("cr_busy_after", busy, 0);
        check_eq("cr_no_wr", wr_log.size(), 0);

        // Address mismatch
        oe_seen = 0; busy_seen = 0; mon_en = 1'b1;
        i2c_start();
        write_byte(8'h74, a); check_eq("am_nack_addr", a, 0);
        write_byte(8'h00, a);
        write_byte(8'hFF, a);
        i2c_stop(); wq();
        mon_en = 1'b0;
        check_eq("am_oe_seen", oe_seen, 0);
        check_eq("am_busy_seen", busy_seen, 0);
        check_eq("am_no_wr", wr_log.size(), 0);

        // Pointer wrap, then direct read from current pointer
        i2c_start();
        write_byte(8'h72, a); write_byte(8'h01, a); write_byte(8'h77, a);
        i2c_stop(); wq();
        i2c_start();
        write_byte(8'h72, a); write_byte(8'h0F, a);
        write_byte(8'h11, a); check_eq("pw_ack_d0", a, 1);
        write_byte(8'h22, a); check_eq("pw_ack_d1", a, 1);
        i2c_stop(); wq();
        check_reg("pw_reg15", 4'd15, 8'h11);
        check_reg("pw_reg0", 4'd0, 8'h22);
        check_reg("pw_reg1", 4'd1, 8'h77);
        i2c_start();
        write_byte(8'h73, a); check_eq("pw_ack_raddr", a, 1);
        read_byte(d, 1'b0); check_eq("pw_direct_rd", d, 8'h77);
        i2c_stop(); wq();

        // Reset during the ACK of a data byte
        i2c_start();
        write_byte(8'h72, a); write_byte(8'h05, a);
        v = 8'h99;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        check_eq("ab_oe_ack", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("ab_oe_rst", sda_oe, 0);
        check_eq("ab_busy_rst", busy, 0);
        scl_m = 1'b1; wq(); scl_m = 1'b0; wq();
        i2c_stop(); wq();
        check_reg("ab_reg5", 4'd5, 8'h00);
        check_eq("ab_oe_end", sda_oe, 0);

        // STOP in the middle of a data byte
        wr_log.delete();
        i2c_start();
        write_byte(8'h72, a); write_byte(8'h02, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop(); wq();
        check_eq("sm_no_wr", wr_log.size(), 0);
        check_eq("sm_busy", busy, 0);
        check_eq("sm_oe", sda_oe, 0);
        check_reg("sm_reg2", 4'd2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
